// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised single-clock FIFO with flush and error pulses
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module fifo_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int AFULL_THR  = 6,
  parameter int AEMPTY_THR = 2,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data_write,
  output logic [WIDTH-1:0] data_read,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    status,
  output logic             err_write,
  output logic             err_read
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_write_q, err_write_d;
  logic             err_read_q, err_read_d;
  logic             rd_acc, wr_acc, mem_we;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_THR));
  assign almost_empty = (count_q <= CW'(AEMPTY_THR));
  assign status       = count_q;
  assign err_write    = err_write_q;
  assign err_read     = err_read_q;

  // A write into a full FIFO is only legal when the same edge frees a slot.
  always_comb begin
    rd_acc      = read && !empty;
    wr_acc      = write && (!full || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_write_d = 1'b0;
    err_read_d  = 1'b0;
    mem_we      = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we      = wr_acc;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      err_write_d = write && !wr_acc;
      err_read_d  = read && !rd_acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_write_q <= 1'b0;
      err_read_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_write_q <= err_write_d;
      err_read_q  <= err_read_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= data_write;
  end

`ifdef FIFO_FWFT_EN
  assign data_read = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_read_q, data_read_d;

  always_comb begin
    data_read_d = data_read_q;
    if (!flush && rd_acc) data_read_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_read_q <= '0;
    else        data_read_q <= data_read_d;
  end

  assign data_read = data_read_q;
`endif

endmodule
